param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of din/dout.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2: DEPTH = 2**ADDR_WIDTH entries; legal range 1..10.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-1: almost_full threshold; legal range 1..DEPTH.
REQ-004 SHALL have parameter AEMPTY_TH, default 1: almost_empty threshold; legal range 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 1: 1 = first-word-fall-through; 0 = registered read.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port flush, input, 1: empties the FIFO in one cycle.
REQ-009 SHALL have port wr_ena, input, 1: write request.
REQ-010 SHALL have port din, input, DATA_WIDTH: write data.
REQ-011 SHALL have port rd_ena, input, 1: read request.
REQ-012 SHALL have port dout, output, DATA_WIDTH: read data.
REQ-013 SHALL have port dout_vld, output, 1: dout holds a valid word.
REQ-014 SHALL have port full, output, 1: count == DEPTH.
REQ-015 SHALL have port empty, output, 1: count == 0.
REQ-016 SHALL have port almost_full, output, 1: count >= AFULL_TH.
REQ-017 SHALL have port almost_empty, output, 1: count <= AEMPTY_TH.
REQ-018 SHALL have port count, output, ADDR_WIDTH+1: current occupancy, 0..DEPTH.
REQ-019 SHALL have port overflow, output, 1: sticky flag; a write was rejected.
REQ-020 SHALL have port underflow, output, 1: sticky flag; a read was rejected.

Function
REQ-021 SHALL keep write and read pointers of ADDR_WIDTH+1 bits, indexing memory with the low ADDR_WIDTH bits; wrap is natural modulo 2**(ADDR_WIDTH+1).
REQ-022 SHALL derive full as (MSBs differ, low bits equal) and empty as (pointers equal); count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
REQ-023 SHALL accept a write when wr_ena && !full (full as at cycle start): store din at wr_ptr and increment wr_ptr.
REQ-024 SHALL accept a read when rd_ena && !empty (empty as at cycle start): increment rd_ptr.
REQ-025 SHALL accept both on simultaneous wr_ena and rd_ena with !full and !empty; count unchanged.
REQ-026 SHALL reject a write when full, even if a read is accepted the same cycle: no bypass, count decrements by 1.
REQ-027 SHALL reject a read when empty, even if a write is accepted the same cycle: no bypass, count becomes 1.
REQ-028 SHALL set overflow the cycle after a rejected write and underflow the cycle after a rejected read; both hold until rst or flush.
REQ-029 SHALL, for FWFT=1, drive dout = mem[rd_ptr] combinationally and dout_vld = !empty; dout is don't-care when empty.
REQ-030 SHALL, for FWFT=0, on an accepted read load dout with mem[rd_ptr] at that edge and assert dout_vld for exactly the next cycle; otherwise dout holds and dout_vld = 0.
REQ-031 SHALL, on flush, set both pointers to 0 and clear overflow, underflow and dout_vld; flush overrides any same-cycle wr_ena/rd_ena, which are neither accepted nor flagged.
REQ-032 SHALL derive full, empty, almost_full, almost_empty and count from registered pointers only, with no combinational path from wr_ena/rd_ena.
REQ-033 SHALL NOT reset or clear memory contents; with FWFT=0, flush leaves dout unchanged.

Reset
REQ-034 SHALL, while rst=1 at a clock edge, set pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, dout_vld = 0 and, for FWFT=0, dout = 0.
REQ-035 SHALL give rst priority over flush, wr_ena and rd_ena; asserting rst mid-stream discards all stored data.

Verification (ADDR_WIDTH=2, DATA_WIDTH=8, AFULL_TH=3, AEMPTY_TH=1 unless noted)
REQ-036 SHALL verify fill/drain: write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; full at count 4; FWFT=1 reads return 0x11..0x44 in order; empty after the 4th read.
REQ-037 SHALL verify overflow: full, then wr_ena=1 with din=0x55 and rd_ena=1 -> 0x11 is read, 0x55 is not stored, count = 3, overflow = 1 next cycle and stays set.
REQ-038 SHALL verify underflow: empty, then rd_ena=1 with wr_ena=1, din=0xA5 -> underflow = 1, count = 1, dout = 0xA5 next cycle (FWFT=1).
REQ-039 SHALL verify wrap: 10 alternating write/read pairs of values 0..9 -> every read matches, count stays in 0..1, no flags set.
REQ-040 SHALL verify flush: count 3 with overflow set, then flush=1 with wr_ena=1 -> count 0, empty 1, overflow 0; the next write of 0x77 is read back first.
REQ-041 SHALL verify FWFT=0: write 0x5A, assert rd_ena for one cycle -> dout = 0x5A and dout_vld = 1 on the following cycle only, dout holds 0x5A afterward; rst mid-stream -> dout = 0, count = 0.

Source files
------------

// File: rtl/param_fifo.sv
// Synchronous FIFO with occupancy flags, sticky over/underflow and selectable
// first-word-fall-through or registered read data.
module param_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2,
   parameter int AFULL_TH   = 2**ADDR_WIDTH - 1,
   parameter int AEMPTY_TH  = 1,
   parameter int FWFT       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_ena,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_ena,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_vld,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] AF_LVL = AFULL_TH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_LVL = AEMPTY_TH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   // Status comes only from the registered pointers, so no request-to-flag path.
   assign count        = wr_ptr - rd_ptr;
   assign empty        = (wr_ptr == rd_ptr);
   assign full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                         (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   assign almost_full  = (count >= AF_LVL);
   assign almost_empty = (count <= AE_LVL);

   assign wr_acc = !rst && !flush && wr_ena && !full;
   assign rd_acc = !rst && !flush && rd_ena && !empty;

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc)
            rd_ptr <= rd_ptr + 1'b1;
         if (wr_ena && full)
            overflow <= 1'b1;
         if (rd_ena && empty)
            underflow <= 1'b1;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign dout     = mem[rd_ptr[ADDR_WIDTH-1:0]];
         assign dout_vld = !empty;
      end else begin : g_reg
         // Flush drops the valid strobe but keeps the last word on dout.
         always_ff @(posedge clk) begin
            if (rst) begin
               dout     <= '0;
               dout_vld <= 1'b0;
            end else if (flush) begin
               dout_vld <= 1'b0;
            end else begin
               dout_vld <= rd_acc;
               if (rd_acc)
                  dout <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: directed vector table, hand sequences for wrap and
// registered-read mode, then random traffic against a queue-based model.
module tb_param_fifo;

   logic       clk;
   logic       rst, flush, wr_ena, rd_ena;
   logic [7:0] din;

   logic [7:0] dout1, dout0;
   logic       vld1, vld0;
   logic       full1, empty1, af1, ae1, ovf1, udf1;
   logic       full0, empty0, af0, ae0, ovf0, udf0;
   logic [2:0] cnt1, cnt0;

   int total = 0;
   int bad   = 0;

   param_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .flush(flush), .wr_ena(wr_ena), .din(din), .rd_ena(rd_ena),
      .dout(dout1), .dout_vld(vld1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(cnt1),
      .overflow(ovf1), .underflow(udf1));

   param_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(0)) u_reg (
      .clk(clk), .rst(rst), .flush(flush), .wr_ena(wr_ena), .din(din), .rd_ena(rd_ena),
      .dout(dout0), .dout_vld(vld0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(cnt0),
      .overflow(ovf0), .underflow(udf0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, flush, wr, rd;
      logic [7:0] din;
      int         e_cnt;
      logic [7:0] e_dout;
      logic       e_ovf, e_udf;
   } vec_t;

   function automatic vec_t mk(input logic r, f, w, rd, input logic [7:0] d,
                               input int c, input logic [7:0] q, input logic o, u);
      vec_t v;
      v.rst = r; v.flush = f; v.wr = w; v.rd = rd; v.din = d;
      v.e_cnt = c; v.e_dout = q; v.e_ovf = o; v.e_udf = u;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Apply inputs, clock once, sample 1 time unit after the edge.
   task automatic step(input logic r, f, w, rd, input logic [7:0] d);
      rst = r; flush = f; wr_ena = w; rd_ena = rd; din = d;
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain queue plus sticky bits and the registered-read word.
   logic [7:0] q[$];
   logic       m_ovf, m_udf, m_v0;
   logic [7:0] m_d0;

   task automatic model(input logic r, f, w, rd, input logic [7:0] d);
      bit was_full, was_empty;
      was_full  = (q.size() == 4);
      was_empty = (q.size() == 0);
      if (r) begin
         q.delete(); m_ovf = 0; m_udf = 0; m_v0 = 0; m_d0 = 8'h00;
      end else if (f) begin
         q.delete(); m_ovf = 0; m_udf = 0; m_v0 = 0;
      end else begin
         if (w && was_full)  m_ovf = 1;
         if (rd && was_empty) m_udf = 1;
         m_v0 = rd && !was_empty;
         if (rd && !was_empty) m_d0 = q.pop_front();
         if (w && !was_full) q.push_back(d);
      end
   endtask

   vec_t tbl[$];

   initial begin
      rst = 1; flush = 0; wr_ena = 0; rd_ena = 0; din = 0;

      // Fill/drain, overflow, underflow, flush.
      tbl.push_back(mk(1,0,0,0,8'h00, 0,8'h00,0,0));
      tbl.push_back(mk(0,0,1,0,8'h11, 1,8'h11,0,0));
      tbl.push_back(mk(0,0,1,0,8'h22, 2,8'h11,0,0));
      tbl.push_back(mk(0,0,1,0,8'h33, 3,8'h11,0,0));
      tbl.push_back(mk(0,0,1,0,8'h44, 4,8'h11,0,0));
      tbl.push_back(mk(0,0,1,1,8'h55, 3,8'h22,1,0));
      tbl.push_back(mk(0,0,0,0,8'h00, 3,8'h22,1,0));
      tbl.push_back(mk(0,0,0,1,8'h00, 2,8'h33,1,0));
      tbl.push_back(mk(0,0,0,1,8'h00, 1,8'h44,1,0));
      tbl.push_back(mk(0,0,0,1,8'h00, 0,8'h00,1,0));
      tbl.push_back(mk(0,0,1,1,8'hA5, 1,8'hA5,1,1));
      tbl.push_back(mk(0,0,1,0,8'h01, 2,8'hA5,1,1));
      tbl.push_back(mk(0,0,1,0,8'h02, 3,8'hA5,1,1));
      tbl.push_back(mk(0,1,1,0,8'h99, 0,8'h00,0,0));
      tbl.push_back(mk(0,0,1,0,8'h77, 1,8'h77,0,0));
      tbl.push_back(mk(0,0,0,1,8'h00, 0,8'h00,0,0));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].flush, tbl[i].wr, tbl[i].rd, tbl[i].din);
         chk($sformatf("v%0d count", i), int'(cnt1), tbl[i].e_cnt);
         chk($sformatf("v%0d empty", i), int'(empty1), int'(tbl[i].e_cnt == 0));
         chk($sformatf("v%0d full", i), int'(full1), int'(tbl[i].e_cnt == 4));
         chk($sformatf("v%0d almost_full", i), int'(af1), int'(tbl[i].e_cnt >= 3));
         chk($sformatf("v%0d almost_empty", i), int'(ae1), int'(tbl[i].e_cnt <= 1));
         chk($sformatf("v%0d overflow", i), int'(ovf1), int'(tbl[i].e_ovf));
         chk($sformatf("v%0d underflow", i), int'(udf1), int'(tbl[i].e_udf));
         chk($sformatf("v%0d dout_vld", i), int'(vld1), int'(tbl[i].e_cnt > 0));
         if (tbl[i].e_cnt > 0)
            chk($sformatf("v%0d dout", i), int'(dout1), int'(tbl[i].e_dout));
         chk($sformatf("v%0d reg count", i), int'(cnt0), tbl[i].e_cnt);
      end

      // Wrap: ten write/read pairs across the pointer rollover.
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 0, 8'(i));
         chk("wrap count1", int'(cnt1), 1);
         chk("wrap dout", int'(dout1), i);
         step(0, 0, 0, 1, 8'h00);
         chk("wrap count0", int'(cnt1), 0);
         chk("wrap flags", int'({ovf1, udf1}), 0);
      end

      // Registered-read mode.
      step(1, 0, 0, 0, 8'h00);
      chk("reg rst dout", int'(dout0), 0);
      chk("reg rst vld", int'(vld0), 0);
      step(0, 0, 1, 0, 8'h5A);
      chk("reg vld before read", int'(vld0), 0);
      chk("reg count 1", int'(cnt0), 1);
      step(0, 0, 0, 1, 8'h00);
      chk("reg dout 5A", int'(dout0), 8'h5A);
      chk("reg vld pulse", int'(vld0), 1);
      step(0, 0, 0, 0, 8'h00);
      chk("reg vld drop", int'(vld0), 0);
      chk("reg dout hold", int'(dout0), 8'h5A);
      step(0, 0, 1, 0, 8'h56);
      step(0, 0, 0, 1, 8'h00);
      chk("reg dout 56", int'(dout0), 8'h56);
      step(0, 1, 0, 0, 8'h00);
      chk("reg flush dout hold", int'(dout0), 8'h56);
      chk("reg flush vld", int'(vld0), 0);
      step(0, 0, 1, 0, 8'h12);
      step(0, 0, 1, 0, 8'h34);
      step(0, 0, 0, 1, 8'h00);
      chk("reg dout 12", int'(dout0), 8'h12);
      step(1, 0, 1, 1, 8'hEE);
      chk("reg midrst dout", int'(dout0), 0);
      chk("reg midrst count", int'(cnt0), 0);
      chk("reg midrst vld", int'(vld0), 0);

      // Random traffic with phase-varying write/read bias.
      model(1, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 8'h00);
      for (int n = 0; n < 3000; n++) begin
         logic r, f, w, rd;
         logic [7:0] d;
         int pw;
         pw = ((n / 150) % 3 == 0) ? 75 : (((n / 150) % 3 == 1) ? 25 : 50);
         r  = ($urandom_range(0, 199) == 0);
         f  = ($urandom_range(0, 63) == 0);
         w  = ($urandom_range(0, 99) < pw);
         rd = ($urandom_range(0, 99) < (100 - pw));
         d  = 8'($urandom);
         model(r, f, w, rd, d);
         step(r, f, w, rd, d);
         chk("rnd count", int'(cnt1), q.size());
         chk("rnd empty", int'(empty1), int'(q.size() == 0));
         chk("rnd full", int'(full1), int'(q.size() == 4));
         chk("rnd almost_full", int'(af1), int'(q.size() >= 3));
         chk("rnd almost_empty", int'(ae1), int'(q.size() <= 1));
         chk("rnd overflow", int'(ovf1), int'(m_ovf));
         chk("rnd underflow", int'(udf1), int'(m_udf));
         chk("rnd dout_vld", int'(vld1), int'(q.size() != 0));
         if (q.size() != 0)
            chk("rnd dout", int'(dout1), int'(q[0]));
         chk("rnd reg count", int'(cnt0), q.size());
         chk("rnd reg ovf/udf", int'({ovf0, udf0}), int'({m_ovf, m_udf}));
         chk("rnd reg vld", int'(vld0), int'(m_v0));
         chk("rnd reg dout", int'(dout0), int'(m_d0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
